// File: rtl/uart_mode_cmd_decoder.sv
// uart_mode_cmd_decoder
//   Parses "M<arg><CR|LF>" mode commands popped from a UART RX FIFO and drives
//   the 2-bit subsystem enable. Each command is answered through the TX FIFO
//   with "OK\r\n" or "ER\r\n". Without a UART override, en follows sw_en.
//   Optional feature macro: MODE_QUERY_EN adds the "M?" query command, which
//   answers "M<en>\r\n" and leaves the mode untouched.
module uart_mode_cmd_decoder #(
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int TO_W        = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw_en,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_rd,
    input  logic       tx_full,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic [1:0] en,
    output logic       uart_ctl,
    output logic       cmd_err
);

    localparam logic [7:0] CH_M  = 8'h4D;
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_Q  = 8'h3F;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, GOT_M, GOT_ARG, RESP} state_t;

    state_t          state;
    logic            gap;
    logic [1:0]      idx;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      cmd_mode;
    logic [7:0]      arg;
    // resp[0] is sent first
    logic [3:0][7:0] resp;

    logic is_digit, is_term, arg_ok, timed_out;

    // Pack a 4-byte reply whose last two bytes are always CR LF
    function automatic logic [3:0][7:0] reply(input logic [7:0] b0, input logic [7:0] b1);
        return {CH_LF, CH_CR, b1, b0};
    endfunction

    // Byte classification of the RX head
    always_comb begin
        is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h33);
        is_term  = (rx_data == CH_CR) || (rx_data == CH_LF);
`ifdef MODE_QUERY_EN
        arg_ok   = is_digit || (rx_data == CH_S) || (rx_data == CH_Q);
`else
        arg_ok   = is_digit || (rx_data == CH_S);
`endif
        timed_out = (to_cnt == TO_LAST);
    end

    // Pop only while parsing, never back-to-back; TX strobe only when FIFO has room
    always_comb begin
        rx_rd   = !rst && !rx_empty && (state != RESP) && !gap;
        tx_wr   = (state == RESP) && !tx_full;
        tx_data = tx_wr ? resp[idx] : 8'h00;
    end

    // Command FSM, mode registers, response sequencing and timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gap      <= 1'b0;
            idx      <= 2'd0;
            to_cnt   <= '0;
            cmd_mode <= 2'b00;
            arg      <= 8'h00;
            resp     <= '0;
            en       <= 2'b00;
            uart_ctl <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            gap     <= rx_rd;
            en      <= uart_ctl ? cmd_mode : sw_en;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    // anything other than 'M' (terminators included) is dropped
                    if (rx_rd && rx_data == CH_M)
                        state <= GOT_M;
                end
                GOT_M: begin
                    if (rx_rd) begin
                        to_cnt <= '0;
                        if (arg_ok) begin
                            arg   <= rx_data;
                            state <= GOT_ARG;
                        end else begin
                            resp    <= reply(8'h45, 8'h52);
                            idx     <= 2'd0;
                            cmd_err <= 1'b1;
                            state   <= RESP;
                        end
                    end else if (timed_out) begin
                        to_cnt  <= '0;
                        cmd_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GOT_ARG: begin
                    if (rx_rd) begin
                        to_cnt <= '0;
                        idx    <= 2'd0;
                        state  <= RESP;
                        if (is_term) begin
                            resp <= reply(8'h4F, 8'h4B);
                            if (arg == CH_S) begin
                                uart_ctl <= 1'b0;
`ifdef MODE_QUERY_EN
                            end else if (arg == CH_Q) begin
                                // report the enable as it stands now
                                resp <= reply(CH_M, 8'h30 + {6'd0, en});
`endif
                            end else begin
                                cmd_mode <= arg[1:0];
                                uart_ctl <= 1'b1;
                            end
                        end else begin
                            resp    <= reply(8'h45, 8'h52);
                            cmd_err <= 1'b1;
                        end
                    end else if (timed_out) begin
                        to_cnt  <= '0;
                        cmd_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    to_cnt <= '0;
                    if (tx_wr) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mode_cmd_decoder.sv
// Directed bench for uart_mode_cmd_decoder (TIMEOUT_CYC reduced to 16).
module tb_uart_mode_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw_en = 2'b00;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd;
    logic       tx_full = 1'b0;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic [1:0] en;
    logic       uart_ctl;
    logic       cmd_err;

    int n_cmp = 0;
    int n_bad = 0;

    // RX FIFO model: the initial block appends at tail, pops advance head
    logic [7:0] rx_buf [0:63];
    int head = 0;
    int tail = 0;
    assign rx_empty = (head == tail);
    assign rx_data  = rx_buf[head[5:0]];

    // TX capture, error pulse count, back-to-back pop detection
    logic [7:0] tx_log [0:63];
    int tx_n = 0;
    int err_n = 0;
    int b2b = 0;
    logic prev_rd = 1'b0;

    uart_mode_cmd_decoder #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .sw_en(sw_en),
        .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
        .en(en), .uart_ctl(uart_ctl), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prev_rd <= rx_rd;
        if (rx_rd) head <= head + 1;
        if (rx_rd && prev_rd) b2b <= b2b + 1;
        if (tx_wr) begin
            tx_log[tx_n[5:0]] <= tx_data;
            tx_n <= tx_n + 1;
        end
        if (cmd_err) err_n <= err_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf[tail[5:0]] = b;
        tail = tail + 1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_tx(input string tag, input int target);
        for (int i = 0; i < 200 && tx_n < target; i++) @(negedge clk);
        check(tag, tx_n, target);
    endtask

    task automatic check_reply(input string tag, input int base, input logic [31:0] exp);
        check(tag, {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]}, exp);
    endtask

    int h0, e0;

    initial begin
        // reset state
        cycles(2);
        check("rst_en", en, 2'b00);
        check("rst_ctl", uart_ctl, 1'b0);
        check("rst_txwr", tx_wr, 1'b0);
        check("rst_err", cmd_err, 1'b0);
        check("rst_rxrd", rx_rd, 1'b0);
        rst = 1'b0;
        cycles(2);

        // 1: switch tracking, one cycle latency
        sw_en = 2'b10;
        #1 check("sw_lat0", en, 2'b00);
        @(negedge clk);
        check("sw_lat1", en, 2'b10);
        check("sw_notx", tx_n, 0);

        // 2: M3\r -> OK, override to 11
        push(8'h4D); push(8'h33); push(8'h0D);
        wait_tx("m3_txn", 4);
        check_reply("m3_ok", 0, 32'h4F4B0D0A);
        cycles(3);
        check("m3_ctl", uart_ctl, 1'b1);
        check("m3_en", en, 2'b11);
        sw_en = 2'b01;
        cycles(3);
        check("m3_hold", en, 2'b11);

        // 3: MS\n -> OK, back to switches
        push(8'h4D); push(8'h53); push(8'h0A);
        wait_tx("ms_txn", 8);
        check_reply("ms_ok", 4, 32'h4F4B0D0A);
        cycles(3);
        check("ms_ctl", uart_ctl, 1'b0);
        check("ms_en", en, 2'b01);
        sw_en = 2'b10;
        @(negedge clk);
        check("ms_track", en, 2'b10);

        // 4: M7\r -> ER with one cmd_err, CR dropped in IDLE
        e0 = err_n;
        push(8'h4D); push(8'h37); push(8'h0D);
        wait_tx("m7_txn", 12);
        check_reply("m7_er", 8, 32'h45520D0A);
        cycles(6);
        check("m7_err", err_n, e0 + 1);
        check("m7_en", en, 2'b10);
        check("m7_drain", head, tail);
        check("m7_notx", tx_n, 12);

        // 5: M2\r with TX stalled after the first byte
        sw_en = 2'b01;
        push(8'h4D); push(8'h32); push(8'h0D);
        for (int i = 0; i < 200 && tx_n < 13; i++) @(negedge clk);
        check("m2_first", tx_n, 13);
        tx_full = 1'b1;
        push(8'h5A);
        h0 = head;
        cycles(10);
        check("m2_stall_n", tx_n, 13);
        check("m2_stall_wr", tx_wr, 1'b0);
        check("m2_nopop", head, h0);
        tx_full = 1'b0;
        wait_tx("m2_txn", 16);
        check_reply("m2_ok", 12, 32'h4F4B0D0A);
        cycles(4);
        check("m2_en", en, 2'b10);
        check("m2_drain", head, tail);

        // 6: lone 'M' times out after 16 cycles
        e0 = err_n;
        h0 = head;
        push(8'h4D);
        for (int i = 0; i < 50 && head == h0; i++) @(negedge clk);
        check("to_pop", head, h0 + 1);
        cycles(15);
        check("to_early", cmd_err, 1'b0);
        @(negedge clk);
        check("to_pulse", cmd_err, 1'b1);
        @(negedge clk);
        check("to_end", cmd_err, 1'b0);
        check("to_notx", tx_n, 16);
        check("to_en", en, 2'b10);
        push(8'h4D); push(8'h31); push(8'h0D);
        wait_tx("m1_txn", 20);
        check_reply("m1_ok", 16, 32'h4F4B0D0A);
        cycles(3);
        check("m1_en", en, 2'b01);
        check("to_errcnt", err_n, e0 + 1);

        // query command
        e0 = err_n;
        push(8'h4D); push(8'h3F); push(8'h0D);
        wait_tx("q_txn", 24);
`ifdef MODE_QUERY_EN
        check_reply("q_resp", 20, 32'h4D310D0A);
        cycles(3);
        check("q_err", err_n, e0);
`else
        check_reply("q_resp", 20, 32'h45520D0A);
        cycles(3);
        check("q_err", err_n, e0 + 1);
`endif
        check("q_en", en, 2'b01);

        // bad terminator after a valid arg
        e0 = err_n;
        push(8'h4D); push(8'h30); push(8'h58);
        wait_tx("bt_txn", 28);
        check_reply("bt_er", 24, 32'h45520D0A);
        cycles(3);
        check("bt_err", err_n, e0 + 1);
        check("bt_en", en, 2'b01);
        check("pop_gap", b2b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
